// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback wins, MUL/DIV results bypass or queue and drain.
// Optional starvation guard (age counter + stall_req) built when WB_ARB_STARVE_GUARD_EN is defined.
module wb_port_arbiter #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 3,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wb_en,
    input  logic [ADDR_W-1:0]         wb_dest,
    input  logic [DATA_W-1:0]         wb_data,
    input  logic                      mc_valid,
    input  logic [ADDR_W-1:0]         mc_dest,
    input  logic [DATA_W-1:0]         mc_data,
    output logic                      mc_ready,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata,
    output logic [ADDR_W-1:0]         wb_op_dest,
    output logic [(1<<ADDR_W)-1:0]    pend_mask,
    output logic                      stall_req
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } mc_entry_t;

    mc_entry_t             fifo_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] slot_vld;
    logic [PTR_W-1:0]      rd_ptr, wr_ptr;
    logic [CNT_W-1:0]      count;
    logic                  empty, full, pop, push, bypass;

    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(FIFO_DEPTH));
    assign pop    = !wb_en && !empty;
    assign bypass = !wb_en && empty && mc_valid;
    assign push   = mc_valid && !full && !bypass;

    // Depth is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            slot_vld <= '0;
        end else begin
            if (push) begin
                wr_ptr           <= wr_ptr + PTR_W'(1);
                slot_vld[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr           <= rd_ptr + PTR_W'(1);
                slot_vld[rd_ptr] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_q[wr_ptr] <= {mc_dest, mc_data};
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (!rst_n) begin
            rf_we = 1'b0;
        end else if (wb_en) begin
            rf_we    = 1'b1;
            rf_waddr = wb_dest;
            rf_wdata = wb_data;
        end else if (!empty) begin
            rf_we    = 1'b1;
            rf_waddr = fifo_q[rd_ptr].dest;
            rf_wdata = fifo_q[rd_ptr].data;
        end else if (mc_valid) begin
            rf_we    = 1'b1;
            rf_waddr = mc_dest;
            rf_wdata = mc_data;
        end
    end

    // Duplicate destinations simply OR into the same bit.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (rst_n && slot_vld[i])
                pend_mask[fifo_q[i].dest] = 1'b1;
        end
    end

    assign mc_ready   = rst_n && !full;
    assign wb_op_dest = rf_we ? rf_waddr : '0;

`ifdef WB_ARB_STARVE_GUARD_EN
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
    logic [AGE_W-1:0] age;

    // Age tracks how long the current head has waited; a pop hands a fresh start to the next head.
    always_ff @(posedge clk) begin
        if (!rst_n || empty || pop)
            age <= '0;
        else if (age != AGE_W'(STARVE_LIMIT))
            age <= age + AGE_W'(1);
    end

    assign stall_req = rst_n && (age == AGE_W'(STARVE_LIMIT));
`else
    // Without the guard the limit has no effect; this compare is constant false.
    assign stall_req = (STARVE_LIMIT < 0);
`endif

endmodule
